// File: rtl/prog_freq_divider.sv
// Runtime-programmable clock divider: programmable period and high time,
// shadowed reconfiguration applied only at period boundaries or while idle.

module prog_freq_divider #(
   parameter int WIDTH        = 26,
   parameter int DEFAULT_DIV  = 2700000,
   parameter int DEFAULT_HIGH = 1350000
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] high_in,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             cfg_pending
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(32'd1);
   localparam logic [WIDTH-1:0] TWO      = WIDTH'(32'd2);
   localparam logic [WIDTH-1:0] RST_DIV  = (DEFAULT_DIV < 32'sd2) ? TWO : WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);

   // Periods shorter than two cycles cannot form a wrap plus a high/low phase.
   function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      if (d < TWO) begin
         r = TWO;
      end else begin
         r = d;
      end
      return r;
   endfunction

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] high_r;
   logic [WIDTH-1:0] shadow_div_r;
   logic [WIDTH-1:0] shadow_high_r;
   logic             clk_out_r;
   logic             tick_r;
   logic             cfg_pending_r;

   logic [WIDTH-1:0] count_s;
   logic [WIDTH-1:0] div_s;
   logic [WIDTH-1:0] high_s;
   logic [WIDTH-1:0] shadow_div_s;
   logic [WIDTH-1:0] shadow_high_s;
   logic             clk_out_s;
   logic             tick_s;
   logic             cfg_pending_s;
   logic [WIDTH-1:0] last_s;
   logic [WIDTH-1:0] load_div_s;
   logic             wrap_s;

   // Next-state logic for the phase counter, active and shadow configuration.
   always_comb begin
      count_s       = count_r;
      div_s         = div_r;
      high_s        = high_r;
      shadow_div_s  = shadow_div_r;
      shadow_high_s = shadow_high_r;
      clk_out_s     = 1'b0;
      tick_s        = 1'b0;
      cfg_pending_s = cfg_pending_r;
      // div_r is never below 2, so this cannot underflow.
      last_s        = div_r - ONE;
      load_div_s    = clamp_div(div_in);
      wrap_s        = enable && (count_r >= last_s);

      if (!enable) begin
         count_s   = '0;
         clk_out_s = 1'b0;
         tick_s    = 1'b0;
         if (cfg_pending_r) begin
            div_s         = shadow_div_r;
            high_s        = shadow_high_r;
            cfg_pending_s = 1'b0;
         end else begin
            cfg_pending_s = 1'b0;
         end
         // A load seen while idle lands on the following idle cycle.
         if (load) begin
            shadow_div_s  = load_div_s;
            shadow_high_s = high_in;
            cfg_pending_s = 1'b1;
         end else begin
            shadow_div_s  = shadow_div_r;
         end
      end else begin
         clk_out_s = (count_r < high_r);
         if (wrap_s) begin
            count_s = '0;
            tick_s  = 1'b1;
            if (load) begin
               div_s         = load_div_s;
               high_s        = high_in;
               shadow_div_s  = load_div_s;
               shadow_high_s = high_in;
               cfg_pending_s = 1'b0;
            end else if (cfg_pending_r) begin
               div_s         = shadow_div_r;
               high_s        = shadow_high_r;
               cfg_pending_s = 1'b0;
            end else begin
               cfg_pending_s = 1'b0;
            end
         end else begin
            count_s = count_r + ONE;
            tick_s  = 1'b0;
            if (load) begin
               shadow_div_s  = load_div_s;
               shadow_high_s = high_in;
               cfg_pending_s = 1'b1;
            end else begin
               cfg_pending_s = cfg_pending_r;
            end
         end
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         count_r       <= '0;
         div_r         <= RST_DIV;
         high_r        <= RST_HIGH;
         shadow_div_r  <= RST_DIV;
         shadow_high_r <= RST_HIGH;
         clk_out_r     <= 1'b0;
         tick_r        <= 1'b0;
         cfg_pending_r <= 1'b0;
      end else begin
         count_r       <= count_s;
         div_r         <= div_s;
         high_r        <= high_s;
         shadow_div_r  <= shadow_div_s;
         shadow_high_r <= shadow_high_s;
         clk_out_r     <= clk_out_s;
         tick_r        <= tick_s;
         cfg_pending_r <= cfg_pending_s;
      end
   end

   assign count       = count_r;
   assign clk_out     = clk_out_r;
   assign tick        = tick_r;
   assign cfg_pending = cfg_pending_r;

   prog_freq_divider_chk #(.WIDTH(WIDTH)) u_chk (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .count   (count_r),
      .div     (div_r),
      .tick    (tick_r)
   );

endmodule

// Invariants of the divider state, kept apart from the datapath.
module prog_freq_divider_chk #(
   parameter int WIDTH = 26
) (
   input logic             clk_in,
   input logic             reset_n,
   input logic [WIDTH-1:0] count,
   input logic [WIDTH-1:0] div,
   input logic             tick
);

   a_count_in_range : assert property (@(posedge clk_in) disable iff (!reset_n) count < div);
   a_div_min        : assert property (@(posedge clk_in) disable iff (!reset_n) div >= WIDTH'(32'd2));
   a_tick_at_zero   : assert property (@(posedge clk_in) disable iff (!reset_n) tick |-> (count == '0));

endmodule
